// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the CPU register bank write side.
//
// Contents:
//   DATA_W, NREGS, ADDR_W  default register width, count and address width
//   reg_addr_t, reg_data_t register address / data types at default widths
//   slot_state_t           readable name for a slot's busy/cancel pair,
//                          intended for debug and waveform decoding
//   decode_slot()          maps the {busy, cancel} bits onto slot_state_t
//
// Optional build macro used elsewhere in this slice: REGFILE_R0_ZERO_EN
// ----------------------------------------------------------------------------
package regfile_pkg;

   localparam int DATA_W = 16;
   localparam int NREGS  = 16;
   localparam int ADDR_W = 4;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

   // Encoding is {busy, cancel}, so the enum value can be read straight off
   // the two scoreboard bits of a slot.
   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      PENDING   = 2'b10,
      CANCELLED = 2'b11
   } slot_state_t;

   // Cancel without busy cannot occur in a healthy slot; it is folded into
   // IDLE so a debug view never shows an undefined name.
   function automatic slot_state_t decode_slot(input logic busy_bit,
                                               input logic cancel_bit);
      slot_state_t st;
      st = IDLE;
      if (busy_bit && cancel_bit) begin
         st = CANCELLED;
      end else if (busy_bit) begin
         st = PENDING;
      end
      return st;
   endfunction

endpackage

// File: rtl/regfile_write_port_slot.sv
// ----------------------------------------------------------------------------
// reg_slot
// One general register plus its load scoreboard entry (busy / cancel).
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   alu_hit    ALU writeback targets this register this cycle
//   ld_hit     a load writeback to this register is accepted this cycle
//   issue_hit  a new load to this register is dispatched this cycle
//   alu_data   shared ALU result bus
//   ld_data    shared load data bus
//   q          current register contents
//   busy       a load to this register is outstanding
//
// The scoreboard has three states held in a 2-bit {busy, cancel} register:
//   IDLE (00)      no load outstanding
//   PENDING (10)   a load is outstanding and will write when it returns
//   CANCELLED (11) a load is outstanding but a younger ALU write already
//                  landed, so the returning load data must be dropped
// ----------------------------------------------------------------------------
module reg_slot
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alu_hit,
   input  logic             ld_hit,
   input  logic             issue_hit,
   input  logic [WIDTH-1:0] alu_data,
   input  logic [WIDTH-1:0] ld_data,
   output logic [WIDTH-1:0] q,
   output logic             busy
);

   localparam logic [1:0] SLOT_IDLE      = 2'b00;
   localparam logic [1:0] SLOT_PENDING   = 2'b10;
   localparam logic [1:0] SLOT_CANCELLED = 2'b11;

   logic [1:0] state;
   logic       cancel;

   assign busy   = state[1];
   assign cancel = state[0];

   // Data register. The ALU always wins the single write port, so alu_hit
   // and ld_hit are never both set; the ordering here only documents that.
   // A load returning into a CANCELLED slot is swallowed so the younger ALU
   // value survives the older load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (alu_hit) begin
         q <= alu_data;
      end else if (ld_hit && !cancel) begin
         q <= ld_data;
      end
   end

   // Scoreboard. A fresh issue always restarts the slot in PENDING, even
   // when the previous load returns or the ALU writes in the same cycle,
   // because the new load is the youngest producer. An accepted load
   // retires the slot. An ALU write while a load is outstanding marks the
   // load as stale; a CANCELLED slot simply stays CANCELLED on more ALU
   // writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SLOT_IDLE;
      end else if (issue_hit) begin
         state <= SLOT_PENDING;
      end else if (ld_hit) begin
         state <= SLOT_IDLE;
      end else if (alu_hit && busy) begin
         state <= SLOT_CANCELLED;
      end
   end

endmodule

// File: rtl/regfile_write_port.sv
// ----------------------------------------------------------------------------
// regfile_write_port
// Write side of the CPU register bank. Owns the general registers, arbitrates
// the single write port between ALU writeback (priority, no handshake) and
// load writeback (valid/ready), and keeps a per-register busy scoreboard for
// outstanding loads with write-after-write cancellation.
//
// Parameters:
//   DATA_W  register width in bits
//   NREGS   number of registers
//   ADDR_W  register address width
//
// Ports:
//   clk            clock
//   rst_n          asynchronous active-low reset
//   alu_we         ALU writeback strobe, always accepted
//   alu_addr       ALU destination register
//   alu_data       ALU result
//   ld_issue       a load to ld_issue_addr has been dispatched
//   ld_issue_addr  destination of the dispatched load
//   ld_valid       load data available
//   ld_addr        load destination register
//   ld_data        load data
//   ld_ready       load writeback accepted this cycle (combinational)
//   regs_out       flat register contents, rN at [N*DATA_W +: DATA_W]
//   busy           bit N set while a load to rN is outstanding
//
// Build option:
//   REGFILE_R0_ZERO_EN  when defined, r0 is hardwired to zero: writes to r0
//                       are dropped, loads to r0 are never marked busy, and
//                       a load returning to r0 still completes its handshake.
// ----------------------------------------------------------------------------
module regfile_write_port
#(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int NREGS  = regfile_pkg::NREGS,
   parameter int ADDR_W = regfile_pkg::ADDR_W
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    alu_we,
   input  logic [ADDR_W-1:0]       alu_addr,
   input  logic [DATA_W-1:0]       alu_data,
   input  logic                    ld_issue,
   input  logic [ADDR_W-1:0]       ld_issue_addr,
   input  logic                    ld_valid,
   input  logic [ADDR_W-1:0]       ld_addr,
   input  logic [DATA_W-1:0]       ld_data,
   output logic                    ld_ready,
   output logic [NREGS*DATA_W-1:0] regs_out,
   output logic [NREGS-1:0]        busy
);

   import regfile_pkg::*;

   logic             ld_accept;
   logic [NREGS-1:0] alu_hit;
   logic [NREGS-1:0] ld_hit;
   logic [NREGS-1:0] issue_hit;

   // The load port is refused whenever the ALU owns the write port, and
   // while in reset so nothing is handshaken that the bank cannot record.
   assign ld_ready  = rst_n & ~alu_we;
   assign ld_accept = ld_valid & ld_ready;

   // One-hot destination decoders. Addresses at or above NREGS match no
   // slot, so they produce neither a write nor a scoreboard change. With the
   // zero-register option every r0 strobe is removed here, which keeps r0 at
   // its reset value of zero and its scoreboard permanently IDLE while the
   // ld_ready handshake is left untouched.
   always_comb begin
      alu_hit   = '0;
      ld_hit    = '0;
      issue_hit = '0;
      for (int i = 0; i < NREGS; i++) begin
         alu_hit[i]   = alu_we    && (alu_addr      == ADDR_W'(i));
         ld_hit[i]    = ld_accept && (ld_addr       == ADDR_W'(i));
         issue_hit[i] = ld_issue  && (ld_issue_addr == ADDR_W'(i));
      end
`ifdef REGFILE_R0_ZERO_EN
      alu_hit[0]   = 1'b0;
      ld_hit[0]    = 1'b0;
      issue_hit[0] = 1'b0;
`else
`endif
   end

   // One slot per register; each slot drives its own slice of the flat
   // output bus and its own busy bit.
   for (genvar g = 0; g < NREGS; g++) begin : g_slot
      reg_slot #(
         .WIDTH     (DATA_W)
      ) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .alu_hit   (alu_hit[g]),
         .ld_hit    (ld_hit[g]),
         .issue_hit (issue_hit[g]),
         .alu_data  (alu_data),
         .ld_data   (ld_data),
         .q         (regs_out[g*DATA_W +: DATA_W]),
         .busy      (busy[g])
      );
   end

endmodule

// File: tb/tb_regfile_write_port.sv
// ----------------------------------------------------------------------------
// tb_regfile_write_port
// Self-checking bench for regfile_write_port. A behavioural model tracks the
// register values, the set of registers with an outstanding load and the set
// whose outstanding load has been overtaken by a younger ALU write. Directed
// scenarios are followed by randomized traffic that honours the load
// valid/ready stability rule.
// Honours REGFILE_R0_ZERO_EN in the same way as the design.
// ----------------------------------------------------------------------------
module tb_regfile_write_port;

   localparam int DW = 16;
   localparam int NR = 16;
   localparam int AW = 4;

`ifdef REGFILE_R0_ZERO_EN
   localparam bit R0Z = 1'b1;
`else
   localparam bit R0Z = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           alu_we;
   logic [AW-1:0]  alu_addr;
   logic [DW-1:0]  alu_data;
   logic           ld_issue;
   logic [AW-1:0]  ld_issue_addr;
   logic           ld_valid;
   logic [AW-1:0]  ld_addr;
   logic [DW-1:0]  ld_data;
   logic           ld_ready;
   logic [NR*DW-1:0] regs_out;
   logic [NR-1:0]  busy;

   int total = 0;
   int bad   = 0;

   // Reference state: value of each register, whether a load is in flight to
   // it, and whether that in-flight load has become stale.
   logic [DW-1:0] mreg [NR];
   bit            mpend[NR];
   bit            mstale[NR];
   bit            lastAccept;

   regfile_write_port dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alu_we        (alu_we),
      .alu_addr      (alu_addr),
      .alu_data      (alu_data),
      .ld_issue      (ld_issue),
      .ld_issue_addr (ld_issue_addr),
      .ld_valid      (ld_valid),
      .ld_addr       (ld_addr),
      .ld_data       (ld_data),
      .ld_ready      (ld_ready),
      .regs_out      (regs_out),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [NR*DW-1:0] obs,
                              input logic [NR*DW-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [NR*DW-1:0] modelFlat();
      logic [NR*DW-1:0] f;
      f = '0;
      for (int n = 0; n < NR; n++) f[n*DW +: DW] = mreg[n];
      return f;
   endfunction

   function automatic logic [NR-1:0] modelBusy();
      logic [NR-1:0] b;
      b = '0;
      for (int n = 0; n < NR; n++) b[n] = mpend[n];
      return b;
   endfunction

   function automatic logic [DW-1:0] regOf(input int n);
      return regs_out[n*DW +: DW];
   endfunction

   task automatic modelReset();
      for (int n = 0; n < NR; n++) begin
         mreg[n]   = '0;
         mpend[n]  = 1'b0;
         mstale[n] = 1'b0;
      end
   endtask

   // Drive one cycle of inputs, check the combinational ready, advance the
   // model over the clock edge and compare the whole visible state.
   task automatic applyStimulus(input bit we, input logic [AW-1:0] aa,
                                input logic [DW-1:0] ad, input bit iss,
                                input logic [AW-1:0] ia, input bit lv,
                                input logic [AW-1:0] la,
                                input logic [DW-1:0] ldd);
      logic [DW-1:0] nreg[NR];
      bit            npend[NR];
      bit            nstale[NR];
      bit            acc;
      alu_we        = we;
      alu_addr      = aa;
      alu_data      = ad;
      ld_issue      = iss;
      ld_issue_addr = ia;
      ld_valid      = lv;
      ld_addr       = la;
      ld_data       = ldd;
      #1;
      checkOutput("ld_ready", ld_ready, rst_n && !we);
      acc        = lv && rst_n && !we;
      lastAccept = acc;
      nreg   = mreg;
      npend  = mpend;
      nstale = mstale;
      if (we) begin
         if (!(R0Z && aa == 0)) nreg[aa] = ad;
      end else if (acc && !mstale[la] && !(R0Z && la == 0)) begin
         nreg[la] = ldd;
      end
      for (int n = 0; n < NR; n++) begin
         if (iss && ia == AW'(n) && !(R0Z && n == 0)) begin
            npend[n]  = 1'b1;
            nstale[n] = 1'b0;
         end else if (acc && la == AW'(n)) begin
            npend[n]  = 1'b0;
            nstale[n] = 1'b0;
         end else if (we && aa == AW'(n) && mpend[n]) begin
            nstale[n] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      mreg   = nreg;
      mpend  = npend;
      mstale = nstale;
      checkOutput("regs", regs_out, modelFlat());
      checkOutput("busy", busy, modelBusy());
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
   endtask

   initial begin
      logic [DW-1:0] exp0;
      bit            hv;
      logic [AW-1:0] ha;
      logic [DW-1:0] hd;
      bit            rwe;
      bit            riss;
      logic [AW-1:0] raa;
      logic [AW-1:0] ria;
      logic [DW-1:0] rad;

      // Power-on reset with ALU idle: ready must still be low.
      rst_n = 1'b0;
      alu_we = 1'b0; alu_addr = '0; alu_data = '0;
      ld_issue = 1'b0; ld_issue_addr = '0;
      ld_valid = 1'b1; ld_addr = 4'd1; ld_data = 16'h7777;
      modelReset();
      #1;
      checkOutput("reset_regs", regs_out, '0);
      checkOutput("reset_busy", busy, '0);
      checkOutput("reset_ready", ld_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      ld_valid = 1'b0;
      rst_n = 1'b1;

      // ALU write only.
      applyStimulus(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
      checkOutput("r5_beef", regOf(5), 16'hBEEF);
      checkOutput("r5_only", busy, '0);

      // ALU and load collide: ALU wins, load waits one cycle.
      applyStimulus(1'b1, 4'd2, 16'h1111, 1'b0, 4'd0, 1'b1, 4'd3, 16'h1234);
      checkOutput("r2_alu", regOf(2), 16'h1111);
      checkOutput("r3_held", regOf(3), 16'h0000);
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'd3, 16'h1234);
      checkOutput("r3_load", regOf(3), 16'h1234);

      // Write-after-write cancellation on r7.
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 1'b0, 4'd0, 16'h0);
      checkOutput("busy7_set", busy[7], 1'b1);
      applyStimulus(1'b1, 4'd7, 16'h00AA, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'd7, 16'h5555);
      checkOutput("r7_kept", regOf(7), 16'h00AA);
      checkOutput("busy7_clr", busy[7], 1'b0);

      // New issue to r4 in the same cycle the older r4 load returns.
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 1'b0, 4'd0, 16'h0);
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 1'b1, 4'd4, 16'h0BAD);
      checkOutput("r4_old", regOf(4), 16'h0BAD);
      checkOutput("busy4_kept", busy[4], 1'b1);
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'd4, 16'h0F0F);
      checkOutput("r4_new", regOf(4), 16'h0F0F);
      checkOutput("busy4_clr", busy[4], 1'b0);

      // Asynchronous reset mid-cycle with a load outstanding to r9.
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 1'b0, 4'd0, 16'h0);
      checkOutput("busy9_set", busy[9], 1'b1);
      ld_issue = 1'b0;
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("async_regs", regs_out, '0);
      checkOutput("async_busy", busy, '0);
      checkOutput("async_ready", ld_ready, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'd9, 16'hCAFE);
      checkOutput("r9_late", regOf(9), 16'hCAFE);

      // Register zero behaviour.
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 1'b0, 4'd0, 16'h0);
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'd0, 16'h1234);
      checkOutput("busy0_clr", busy[0], 1'b0);
      applyStimulus(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
      exp0 = R0Z ? 16'h0000 : 16'hFFFF;
      checkOutput("r0_value", regOf(0), exp0);
      idleCycle();

      // Randomized traffic; a presented load is held until it is accepted.
      hv = 1'b0;
      ha = '0;
      hd = '0;
      for (int c = 0; c < 600; c++) begin
         rwe  = ($urandom_range(0, 3) == 0);
         riss = ($urandom_range(0, 3) == 0);
         raa  = AW'($urandom_range(0, 7));
         ria  = AW'($urandom_range(0, 7));
         rad  = DW'($urandom);
         if (!hv) begin
            hv = ($urandom_range(0, 1) == 1);
            ha = AW'($urandom_range(0, 7));
            hd = DW'($urandom);
         end
         applyStimulus(rwe, raa, rad, riss, ria, hv, ha, hd);
         if (lastAccept) hv = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
